// File: rtl/min_os_frame_tx_pkg.sv
// Shared MinOS frame definitions: header default, FSM state encodings, frame lengths.
// Frame length depends on MIN_OS_FRAME_CHECKSUM_EN (trailing XOR checksum byte).
package min_os_frame_tx_pkg;

   localparam logic [7:0] HEADER_BYTE_DEF   = 8'h44;
   localparam int         DISPLAY_BYTES_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_LED  = 3'd2,
      ST_PAY  = 3'd3,
      ST_CHK  = 3'd4
   } frame_state_e;

`ifdef MIN_OS_FRAME_CHECKSUM_EN
   localparam int FRAME_OVERHEAD = 3;
`else
   localparam int FRAME_OVERHEAD = 2;
`endif

   // Also consumed by the MinOS RX side to size its frame buffer.
   localparam int FRAME_LEN_DEF = DISPLAY_BYTES_DEF + FRAME_OVERHEAD;

endpackage

// File: rtl/min_os_frame_tx_if.sv
// Byte-stream valid/ready link from the frame serialiser to the MinOS UART TX.
interface min_os_frame_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/min_os_frame_tx_refresh_timer.sv
// Idle refresh timer: counts up while enabled, saturates at REFRESH_TICKS-1.
// REFRESH_TICKS = 0 disables the timer (expired never asserts).
module min_os_frame_tx_refresh_timer #(
   parameter logic [31:0] REFRESH_TICKS = 32'd100000000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [31:0] LAST_TICK = REFRESH_TICKS - 32'd1;

   logic [31:0] cnt_q;
   logic        at_last;

   assign at_last = (cnt_q == LAST_TICK);
   assign expired = (REFRESH_TICKS != 32'd0) && at_last;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && !at_last) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

endmodule

// File: rtl/min_os_frame_tx.sv
// MinOS frame transmitter: snapshots LED byte + display buffer and streams a frame
// to the UART TX. Optional trailing XOR checksum under MIN_OS_FRAME_CHECKSUM_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no frame; waiting for update, pending or refresh expiry
// ST_HDR  | offering HEADER_BYTE
// ST_LED  | offering shadow LED byte
// ST_PAY  | offering shadow display byte idx_q
// ST_CHK  | offering XOR of all previous frame bytes (checksum build)
module min_os_frame_tx
   import min_os_frame_tx_pkg::*;
#(
   parameter logic [7:0]  HEADER_BYTE   = HEADER_BYTE_DEF,
   parameter int          DISPLAY_BYTES = DISPLAY_BYTES_DEF,
   parameter logic [31:0] REFRESH_TICKS = 32'd100000000
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic [7:0]                 leds,
   input  logic [DISPLAY_BYTES*8-1:0] display,
   input  logic                       update,
   min_os_frame_tx_if.master          tx,
   output logic                       busy
);

   localparam int IW = $clog2(DISPLAY_BYTES);

   frame_state_e state_q, state_d;
   logic [6:0]   idx_q, idx_d;
   logic [7:0]   leds_q;
   logic [7:0]   shadow_q [DISPLAY_BYTES];
   logic         pending_q;
   logic         start;
   logic         transfer;
   logic         last_pay;
   logic         tmr_expired;
   logic [7:0]   tx_byte;
   logic [7:0]   pay_byte;

   assign transfer = tx.tx_valid && tx.tx_ready;
   assign start    = (state_q == ST_IDLE) && (update || pending_q || tmr_expired);
   assign last_pay = (idx_q == 7'(DISPLAY_BYTES - 1));
   assign pay_byte = shadow_q[idx_q[IW-1:0]];

   min_os_frame_tx_refresh_timer #(
      .REFRESH_TICKS (REFRESH_TICKS)
   ) u_refresh_timer (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .clear   (start),
      .enable  ((state_q == ST_IDLE) && !start),
      .expired (tmr_expired)
   );

`ifdef MIN_OS_FRAME_CHECKSUM_EN
   logic [7:0] chk_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         chk_q <= '0;
      end else if (start) begin
         chk_q <= '0;
      end else if (transfer && (state_q != ST_CHK)) begin
         chk_q <= chk_q ^ tx_byte;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_HDR;
         ST_HDR:  if (transfer) state_d = ST_LED;
         ST_LED: begin
            if (transfer) begin
               state_d = ST_PAY;
               idx_d   = '0;
            end
         end
         ST_PAY: begin
            if (transfer) begin
               if (last_pay) begin
                  idx_d = '0;
`ifdef MIN_OS_FRAME_CHECKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_IDLE;
`endif
               end else begin
                  idx_d = idx_q + 7'd1;
               end
            end
         end
`ifdef MIN_OS_FRAME_CHECKSUM_EN
         ST_CHK:  if (transfer) state_d = ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_byte = 8'h00;
      case (state_q)
         ST_HDR:  tx_byte = HEADER_BYTE;
         ST_LED:  tx_byte = leds_q;
         ST_PAY:  tx_byte = pay_byte;
`ifdef MIN_OS_FRAME_CHECKSUM_EN
         ST_CHK:  tx_byte = chk_q;
`endif
         default: tx_byte = 8'h00;
      endcase
   end

   assign tx.tx_data  = tx_byte;
   assign tx.tx_valid = (state_q != ST_IDLE);
   assign busy        = (state_q != ST_IDLE);

   // An update coinciding with a pending/refresh start still earns a follow-up frame.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (start) begin
            pending_q <= update && (pending_q || tmr_expired);
         end else if (update && (state_q != ST_IDLE)) begin
            pending_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (start) begin
         leds_q <= leds;
         for (int i = 0; i < DISPLAY_BYTES; i++) begin
            shadow_q[i] <= display[i*8 +: 8];
         end
      end
   end

endmodule

// File: tb/tb_min_os_frame_tx.sv
// Directed bench for min_os_frame_tx: reset, basic frame, backpressure, mid-frame update,
// mid-frame reset and periodic refresh. Expected frame length follows MIN_OS_FRAME_CHECKSUM_EN.
module tb_min_os_frame_tx;

`ifdef MIN_OS_FRAME_CHECKSUM_EN
   localparam int FL = 67;
`else
   localparam int FL = 66;
`endif

   logic         CLK;
   logic         RST_N;
   logic         rst2;
   logic [7:0]   leds;
   logic [511:0] disp1;
   logic         update;
   logic         busy1;
   logic [7:0]   leds2;
   logic [511:0] disp2;
   logic         update2;
   logic         busy2;

   int n_cmp;
   int n_err;

   logic [7:0] exp_b [0:79];
   logic [7:0] got_b [0:79];

   min_os_frame_tx_if tx1 ();
   min_os_frame_tx_if tx2 ();

   min_os_frame_tx #(
      .HEADER_BYTE   (8'h44),
      .DISPLAY_BYTES (64),
      .REFRESH_TICKS (32'd0)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .leds    (leds),
      .display (disp1),
      .update  (update),
      .tx      (tx1.master),
      .busy    (busy1)
   );

   min_os_frame_tx #(
      .HEADER_BYTE   (8'h44),
      .DISPLAY_BYTES (64),
      .REFRESH_TICKS (32'd100)
   ) dut_rfs (
      .CLK     (CLK),
      .RST_N   (rst2),
      .leds    (leds2),
      .display (disp2),
      .update  (update2),
      .tx      (tx2.master),
      .busy    (busy2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic build_exp(input logic [7:0] l, input logic [511:0] d);
      logic [7:0] x;
      exp_b[0] = 8'h44;
      exp_b[1] = l;
      x = 8'h44 ^ l;
      for (int i = 0; i < 64; i++) begin
         exp_b[2+i] = d[i*8 +: 8];
         x = x ^ d[i*8 +: 8];
      end
      exp_b[66] = x;
   endtask

   task automatic pulse_update();
      update = 1'b1;
      tick();
      update = 1'b0;
   endtask

   task automatic wait_valid(input int bound, output int cyc);
      cyc = 0;
      while (tx1.tx_valid !== 1'b1 && cyc < bound) begin
         tick();
         cyc++;
      end
   endtask

   // Accepts bytes from dut while tx_valid is high; optional stall, update pulses,
   // display change and reset injection keyed on the accepted-byte index.
   task automatic run_frame(input int stall_idx, input int stall_len,
                            input int upd_a, input int upd_b, input int upd_c,
                            input int chg_at, input int abort_at,
                            output int n, output int busy_n);
      int stalls;
      int guard;
      bit aborted;
      n = 0; busy_n = 0; stalls = 0; guard = 0; aborted = 1'b0;
      while (tx1.tx_valid === 1'b1 && guard < 400 && !aborted) begin
         guard++;
         if (busy1 === 1'b1) busy_n++;
         update = (n == upd_a) || (n == upd_b) || (n == upd_c);
         if (n == chg_at) disp1[7*8 +: 8] = 8'h0C;
         if (n == abort_at) begin
            RST_N   = 1'b0;
            aborted = 1'b1;
         end else if (n == stall_idx && stalls < stall_len) begin
            tx1.tx_ready = 1'b0;
            check($sformatf("stall_data_%0d", stalls), tx1.tx_data, exp_b[n]);
            check($sformatf("stall_valid_%0d", stalls), tx1.tx_valid, 1);
            stalls++;
         end else begin
            tx1.tx_ready = 1'b1;
            got_b[n] = tx1.tx_data;
            n++;
         end
         tick();
      end
      update = 1'b0;
      tx1.tx_ready = 1'b1;
   endtask

   task automatic cmp_frame(input string tag, input int n, input int b, input int extra);
      check({tag, "_len"}, n, FL);
      for (int i = 0; i < FL; i++) begin
         check($sformatf("%s_byte%0d", tag, i), got_b[i], exp_b[i]);
      end
      check({tag, "_busy_cycles"}, b, FL + extra);
   endtask

   task automatic rfs_gap(input string tag);
      int c;
      c = 0;
      while (tx2.tx_valid !== 1'b1 && c < 300) begin
         tick();
         c++;
      end
      check(tag, c, 100);
   endtask

   task automatic rfs_frame(input string tag);
      int n2;
      logic [7:0] f0, f1, last;
      n2 = 0; f0 = '0; f1 = '0; last = '0;
      while (tx2.tx_valid === 1'b1 && n2 < 100) begin
         if (n2 == 0) f0 = tx2.tx_data;
         if (n2 == 1) f1 = tx2.tx_data;
         last = tx2.tx_data;
         n2++;
         tick();
      end
      check({tag, "_len"}, n2, FL);
      check({tag, "_hdr"}, f0, 8'h44);
      check({tag, "_led"}, f1, 8'h5A);
`ifdef MIN_OS_FRAME_CHECKSUM_EN
      check({tag, "_chk"}, last, 8'h69);
`else
      check({tag, "_last_pay"}, last, 8'h77);
`endif
   endtask

   initial begin
      int n, b, cyc;
      n_cmp = 0; n_err = 0;
      RST_N = 1'b0; rst2 = 1'b0; update = 1'b0; update2 = 1'b0;
      leds = 8'hA5; disp1 = '0; disp1[7:0] = 8'h30;
      leds2 = 8'h5A; disp2 = '0; disp2[63*8 +: 8] = 8'h77;
      tx1.tx_ready = 1'b1; tx2.tx_ready = 1'b1;

      // reset
      repeat (3) tick();
      check("rst_valid", tx1.tx_valid, 0);
      check("rst_busy", busy1, 0);
      check("rst_data", tx1.tx_data, 0);
      RST_N = 1'b1;
      wait_valid(20, cyc);
      check("rst_no_frame", cyc, 20);

      // basic frame
      build_exp(leds, disp1);
      pulse_update();
      check("hdr_lat_valid", tx1.tx_valid, 1);
      check("hdr_lat_data", tx1.tx_data, 8'h44);
      check("hdr_lat_busy", busy1, 1);
      run_frame(-1, 0, -1, -1, -1, -1, -1, n, b);
      cmp_frame("basic", n, b, 0);
      check("basic_end_valid", tx1.tx_valid, 0);
      check("basic_end_busy", busy1, 0);
      check("basic_led", got_b[1], 8'hA5);
      check("basic_pay0", got_b[2], 8'h30);
`ifdef MIN_OS_FRAME_CHECKSUM_EN
      check("basic_chk", got_b[66], 8'hD1);
`else
      check("basic_last", got_b[65], 8'h00);
`endif

      // backpressure at byte 10
      pulse_update();
      run_frame(10, 5, -1, -1, -1, -1, -1, n, b);
      cmp_frame("stall", n, b, 5);

      // mid-frame update: frame 1 keeps snapshot, exactly one follow-up frame
      build_exp(leds, disp1);
      pulse_update();
      run_frame(-1, 0, 5, 30, 50, 3, -1, n, b);
      cmp_frame("mid_f1", n, b, 0);
      wait_valid(40, cyc);
      check("mid_f2_gap", cyc, 1);
      build_exp(leds, disp1);
      run_frame(-1, 0, -1, -1, -1, -1, -1, n, b);
      cmp_frame("mid_f2", n, b, 0);
      check("mid_f2_pay7", got_b[9], 8'h0C);
      wait_valid(40, cyc);
      check("mid_no_f3", cyc, 40);

      // reset at payload byte 20 with an update pending
      build_exp(leds, disp1);
      pulse_update();
      run_frame(-1, 0, 5, -1, -1, -1, 22, n, b);
      check("abort_idx", n, 22);
      check("abort_valid", tx1.tx_valid, 0);
      check("abort_busy", busy1, 0);
      check("abort_data", tx1.tx_data, 0);
      RST_N = 1'b1;
      wait_valid(40, cyc);
      check("abort_pending_clr", cyc, 40);
      pulse_update();
      check("post_rst_hdr", tx1.tx_data, 8'h44);
      check("post_rst_valid", tx1.tx_valid, 1);
      run_frame(-1, 0, -1, -1, -1, -1, -1, n, b);
      cmp_frame("post_rst", n, b, 0);

      // periodic refresh on the second instance
      rst2 = 1'b1;
      rfs_gap("rfs_gap0");
      rfs_frame("rfs_f1");
      rfs_gap("rfs_gap1");
      rfs_frame("rfs_f2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
